steer_dr_n: RTL and testbench
=============================

# steer_dr_n

Clocked, parametrised N-way steering element for dual-rail (NULL convention) words. A W-bit dual-rail word on the input channel is routed to exactly one of N output channels, selected by a 1-of-N steer code. The steer code can be forwarded downstream for pipelined steering, and four-phase DATA/NULL handshakes are preserved on every channel. It sits in the steering library as the generalised successor of the fixed 3-way, 1-bit steer, for synchronous islands that exchange tokens with NCL-style neighbours.

## Interface
- W, 4: data bits per word; each bit uses 2 rails.
- N, 3: output channels (N ≥ 2).
- CNT_W, 8: per-channel token counter width.
- STEER_FWD, 1: 1 forwards the steer code on steer_o and joins steer_comp_i; 0 ties steer_o to NULL and ignores steer_comp_i.
- clk  in  1  single clock, rising edge.
- init_n  in  1  asynchronous, active-low reset.
- a_i  in  2W  input word; bit b: a_i[2b] = DATA0 rail, a_i[2b+1] = DATA1 rail.
- steer_i  in  N  1-of-N steer code; all-zero = NULL.
- a_comp_o  out  1  input completion; 1 = DATA accepted, request NULL.
- steer_comp_o  out  1  copy of a_comp_o.
- dout_o  out  N·2W  channel k occupies [k·2W +: 2W], with the same rail layout as a_i.
- dout_comp_i  in  N  downstream completion per channel; 1 = holding DATA, 0 = requesting DATA.
- steer_o  out  N  forwarded 1-of-N steer code.
- steer_comp_i  in  1  completion of the steer consumer.
- err_o  out  1  sticky protocol error.
- cnt_o  out  N·CNT_W  tokens delivered per channel.
- cnt_clr_i  in  1  synchronous clear of all counters.

## Operation
- Input classification (combinational, every cycle):
  - DATA: every bit has exactly one rail high and steer_i is one-hot.
  - NULL: all rails low and steer_i == 0.
  - ILLEGAL: any bit has both rails high, or steer_i has more than one bit high.
  - Anything else is partial and is ignored.
- FSM states: IDLE, HOLD, ERR.
- IDLE: all outputs NULL; a_comp_o = 0.
  - Go to HOLD when the input is DATA with sel = k, dout_comp_i[k] = 0, and (steer_comp_i = 0 or STEER_FWD = 0).
  - On that transition: register the word onto channel k, set steer_o = 1<<k (if STEER_FWD), set a_comp_o = 1, and increment cnt[k].
- HOLD: channel k holds DATA; every other channel stays NULL.
  - Go to IDLE when the input is NULL, dout_comp_i[k] = 1, and (steer_comp_i = 1 or STEER_FWD = 0).
  - On that transition: channel k and steer_o return to NULL; a_comp_o = 0.
  - Input changes while in HOLD other than the return to NULL are ignored, because the word is latched.
- ERR: entered from any state when the input is ILLEGAL.
  - All outputs go NULL and err_o = 1.
  - Left only by reset.
- Counters: wrap modulo 2^CNT_W. cnt_clr_i takes priority over a same-cycle increment, so that cycle ends with cnt = 0.
- Channels not selected ignore their dout_comp_i.

## Timing
- Every output is registered.
- Reset (asynchronous on init_n low): state = IDLE; dout_o, steer_o, a_comp_o, steer_comp_o, err_o and cnt_o all 0.
- Forward latency: 1 clk from the edge that samples DATA to DATA on dout_o and a_comp_o = 1.
- Return latency: 1 clk from the edge that samples NULL plus the completion condition to NULL on dout_o and a_comp_o = 0.
- Minimum token cycle: 2 clk, with inputs responding combinationally.
- ILLEGAL and a valid transition in the same cycle: ILLEGAL wins.
- Reset deasserted mid-token: the block restarts in IDLE. Upstream sees a_comp_o = 0 and must re-present DATA, or present NULL first.

## Structure
- Shared package ncl_pkg contains:
  - typedef dr_bit_t (2 rails);
  - constants RAIL0 = 0 and RAIL1 = 1;
  - functions dr_is_data, dr_is_null, dr_is_illegal, onehot_ok.
- Sub-module ncl_dr_completion, parametrised on W, outputs all_data, all_null and any_illegal. Reused by later dual-rail blocks.

## Test plan
- W=4, N=3. a_i = 8'b01_10_01_10, steer_i = 3'b010, all COMP = 0.
  - Cycle +1: dout_o[15:8] = 8'b01100110, channels 0 and 2 = 0, steer_o = 3'b010, a_comp_o = 1, cnt[1] = 1.
  - Then drive the input NULL with dout_comp_i[1] = 1 and steer_comp_i = 1. Cycle +1: everything NULL, a_comp_o = 0.
- DATA for channel 2 while dout_comp_i[2] = 1: the block stays in IDLE with outputs NULL. Dropping dout_comp_i[2] to 0 gives DATA one cycle later.
- Drive a_i[1:0] = 2'b11: err_o = 1 next cycle and all outputs NULL. The state survives further valid tokens until init_n is pulsed low, after which all outputs are 0.
- steer_i = 3'b011 with valid data → err_o = 1.
- STEER_FWD = 0: steer_o stays 0, and toggling steer_comp_i has no effect on the handshake.
- CNT_W = 2: send 5 tokens to channel 0 → cnt[0] = 1. Assert cnt_clr_i on the same cycle as a token → cnt[0] = 0.

Source files
------------

// File: rtl/ncl_pkg.sv
// Shared dual-rail (NULL convention) types and rail classification helpers.
// Latency: none, pure functions and constants.
// Backpressure: not applicable.
package ncl_pkg;

    typedef logic [1:0] dr_bit_t;

    localparam int RAIL0 = 0;
    localparam int RAIL1 = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_ERR  = 2'd2
    } steer_st_t;

    function automatic logic dr_is_data(dr_bit_t b);
        return b[RAIL0] ^ b[RAIL1];
    endfunction

    function automatic logic dr_is_null(dr_bit_t b);
        return b == 2'b00;
    endfunction

    function automatic logic dr_is_illegal(dr_bit_t b);
        return b[RAIL0] & b[RAIL1];
    endfunction

    // Exactly one bit set; callers zero-extend narrower codes.
    function automatic logic onehot_ok(logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/steer_dr_n_if.sv
// Channel bundle of the dual-rail steer: input word/steer, N outputs, completions.
// Latency: wiring only.
// Backpressure: four-phase completion signals travel against the data direction.
interface steer_dr_n_if #(
    parameter int W = 4,
    parameter int N = 3
);
    logic [2*W-1:0]   a_i;
    logic [N-1:0]     steer_i;
    logic             a_comp_o;
    logic             steer_comp_o;
    logic [N*2*W-1:0] dout_o;
    logic [N-1:0]     dout_comp_i;
    logic [N-1:0]     steer_o;
    logic             steer_comp_i;

    modport master (
        output a_i, steer_i, dout_comp_i, steer_comp_i,
        input  a_comp_o, steer_comp_o, dout_o, steer_o
    );

    modport slave (
        input  a_i, steer_i, dout_comp_i, steer_comp_i,
        output a_comp_o, steer_comp_o, dout_o, steer_o
    );
endinterface

// File: rtl/ncl_dr_completion.sv
// Completion detector for a W-bit dual-rail word: all DATA, all NULL, any illegal.
// Latency: combinational.
// Backpressure: none.
module ncl_dr_completion
    import ncl_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [2*W-1:0] a,
    output logic           all_data,
    output logic           all_null,
    output logic           any_illegal
);

    always_comb begin
        all_data    = 1'b1;
        all_null    = 1'b1;
        any_illegal = 1'b0;
        for (int b = 0; b < W; b++) begin
            if (!dr_is_data(a[2*b +: 2]))   all_data    = 1'b0;
            if (!dr_is_null(a[2*b +: 2]))   all_null    = 1'b0;
            if (dr_is_illegal(a[2*b +: 2])) any_illegal = 1'b1;
        end
    end

endmodule

// File: rtl/steer_dr_n.sv
// Routes one dual-rail word to one of N channels chosen by a 1-of-N steer code.
// Latency: 1 clk DATA-in to DATA-out, 1 clk NULL-in to NULL-out.
// Backpressure: holds off while the target channel or steer consumer still holds DATA.
module steer_dr_n
    import ncl_pkg::*;
#(
    parameter int W         = 4,
    parameter int N         = 3,
    parameter int CNT_W     = 8,
    parameter int STEER_FWD = 1
) (
    input  logic               clk,
    input  logic               init_n,
    steer_dr_n_if.slave        ch,
    output logic               err_o,
    output logic [N*CNT_W-1:0] cnt_o,
    input  logic               cnt_clr_i
);

    logic all_data, all_null, any_illegal;

    ncl_dr_completion #(.W(W)) u_comp (
        .a           (ch.a_i),
        .all_data    (all_data),
        .all_null    (all_null),
        .any_illegal (any_illegal)
    );

    steer_st_t                   state;
    logic [N-1:0]                sel_r;
    logic [N-1:0][2*W-1:0]       dout_r;
    logic [N-1:0]                steer_r;
    logic                        comp_r;
    logic                        err_r;
    logic [N-1:0][CNT_W-1:0]     cnt_r;

    logic steer_1hot, steer_multi;
    logic in_data, in_null, in_ill;
    logic fwd_take, fwd_rel;
    logic take, rel;

    assign steer_1hot  = onehot_ok(32'(ch.steer_i));
    assign steer_multi = (ch.steer_i != '0) && !steer_1hot;
    assign in_data     = all_data && steer_1hot;
    assign in_null     = all_null && (ch.steer_i == '0);
    assign in_ill      = any_illegal || steer_multi;

    // With forwarding disabled the steer consumer is treated as always ready.
    assign fwd_take = (STEER_FWD == 0) || !ch.steer_comp_i;
    assign fwd_rel  = (STEER_FWD == 0) ||  ch.steer_comp_i;

    assign take = (state == ST_IDLE) && in_data && !in_ill
                  && ((ch.dout_comp_i & ch.steer_i) == '0) && fwd_take;
    assign rel  = (state == ST_HOLD) && in_null && !in_ill
                  && ((ch.dout_comp_i & sel_r) != '0) && fwd_rel;

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state   <= ST_IDLE;
            sel_r   <= '0;
            dout_r  <= '0;
            steer_r <= '0;
            comp_r  <= 1'b0;
            err_r   <= 1'b0;
            cnt_r   <= '0;
        end else begin
            if (in_ill && state != ST_ERR) begin
                state   <= ST_ERR;
                sel_r   <= '0;
                dout_r  <= '0;
                steer_r <= '0;
                comp_r  <= 1'b0;
                err_r   <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: if (take) begin
                        state   <= ST_HOLD;
                        sel_r   <= ch.steer_i;
                        for (int k = 0; k < N; k++)
                            dout_r[k] <= ch.steer_i[k] ? ch.a_i : '0;
                        steer_r <= (STEER_FWD != 0) ? ch.steer_i : '0;
                        comp_r  <= 1'b1;
                    end
                    ST_HOLD: if (rel) begin
                        state   <= ST_IDLE;
                        sel_r   <= '0;
                        dout_r  <= '0;
                        steer_r <= '0;
                        comp_r  <= 1'b0;
                    end
                    ST_ERR:  ;
                    default: state <= ST_ERR;
                endcase
            end

            // Clear beats a same-cycle token so the cycle ends at zero.
            if (cnt_clr_i) begin
                cnt_r <= '0;
            end else if (take) begin
                for (int k = 0; k < N; k++)
                    if (ch.steer_i[k]) cnt_r[k] <= cnt_r[k] + CNT_W'(1);
            end
        end
    end

    assign ch.dout_o       = dout_r;
    assign ch.steer_o      = steer_r;
    assign ch.a_comp_o     = comp_r;
    assign ch.steer_comp_o = comp_r;
    assign err_o           = err_r;
    assign cnt_o           = cnt_r;

endmodule

// File: tb/tb_steer_dr_n.sv
// Drives two steer instances (forwarding/8-bit counters and no-forwarding/2-bit
// counters) with shared stimulus and compares both against a token-level model.
module tb_steer_dr_n;

    localparam int W = 4;
    localparam int N = 3;

    logic       clk = 1'b0;
    logic       init_n;
    logic [7:0] a;
    logic [2:0] s, dc;
    logic       sc, clr;

    always #5 clk = ~clk;

    steer_dr_n_if #(.W(W), .N(N)) ifa ();
    steer_dr_n_if #(.W(W), .N(N)) ifb ();

    assign ifa.a_i = a;  assign ifa.steer_i = s;  assign ifa.dout_comp_i = dc;  assign ifa.steer_comp_i = sc;
    assign ifb.a_i = a;  assign ifb.steer_i = s;  assign ifb.dout_comp_i = dc;  assign ifb.steer_comp_i = sc;

    logic        err_a, err_b;
    logic [23:0] cnt_a;
    logic [5:0]  cnt_b;

    steer_dr_n #(.W(W), .N(N), .CNT_W(8), .STEER_FWD(1)) dut_a (
        .clk(clk), .init_n(init_n), .ch(ifa), .err_o(err_a), .cnt_o(cnt_a), .cnt_clr_i(clr)
    );
    steer_dr_n #(.W(W), .N(N), .CNT_W(2), .STEER_FWD(0)) dut_b (
        .clk(clk), .init_n(init_n), .ch(ifb), .err_o(err_b), .cnt_o(cnt_b), .cnt_clr_i(clr)
    );

    // Token-level reference: is a word held, on which channel, is the error latched.
    int         m_busy [2];
    int         m_ch   [2];
    int         m_err  [2];
    logic [7:0] m_word [2];
    int         m_cnt  [2][3];
    int         fwd    [2] = '{1, 0};
    int         cw     [2] = '{8, 2};

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_busy[i] = 0; m_ch[i] = 0; m_err[i] = 0; m_word[i] = 8'h00;
            for (int k = 0; k < 3; k++) m_cnt[i][k] = 0;
        end
    endfunction

    function automatic void model_step();
        int pop, ones, k, ill, dat, nul, inc;
        pop = $countones(s);
        ill = (pop > 1) ? 1 : 0;
        dat = (pop == 1) ? 1 : 0;
        nul = (a == 8'h00 && s == 3'b000) ? 1 : 0;
        for (int b = 0; b < W; b++) begin
            ones = int'(a[2*b]) + int'(a[2*b+1]);
            if (ones == 2) ill = 1;
            if (ones != 1) dat = 0;
        end
        k = 0;
        for (int j = 0; j < 3; j++) if (s[j]) k = j;
        for (int i = 0; i < 2; i++) begin
            inc = 0;
            if (m_err[i] != 0) begin
            end else if (ill != 0) begin
                m_err[i] = 1; m_busy[i] = 0;
            end else if (m_busy[i] == 0) begin
                if (dat != 0 && !dc[k] && (fwd[i] == 0 || !sc)) begin
                    m_busy[i] = 1; m_ch[i] = k; m_word[i] = a; inc = 1;
                end
            end else if (nul != 0 && dc[m_ch[i]] && (fwd[i] == 0 || sc)) begin
                m_busy[i] = 0;
            end
            if (clr) begin
                for (int j = 0; j < 3; j++) m_cnt[i][j] = 0;
            end else if (inc != 0) begin
                m_cnt[i][k] = (m_cnt[i][k] + 1) % (1 << cw[i]);
            end
        end
    endfunction

    function automatic logic [31:0] exp_dout(int i);
        logic [31:0] v;
        v = {24'b0, m_word[i]};
        if (m_busy[i] == 0) return 32'd0;
        return v << (8 * m_ch[i]);
    endfunction

    function automatic logic [31:0] exp_steer(int i);
        if (m_busy[i] == 0 || fwd[i] == 0) return 32'd0;
        return 32'd1 << m_ch[i];
    endfunction

    function automatic logic [31:0] exp_cnt(int i);
        logic [31:0] v;
        v = 32'd0;
        for (int k = 0; k < 3; k++) v = v | (32'(m_cnt[i][k]) << (k * cw[i]));
        return v;
    endfunction

    task automatic check_outs();
        chk("a.dout",       32'(ifa.dout_o),       exp_dout(0));
        chk("a.steer_o",    32'(ifa.steer_o),      exp_steer(0));
        chk("a.a_comp",     32'(ifa.a_comp_o),     32'(m_busy[0]));
        chk("a.steer_comp", 32'(ifa.steer_comp_o), 32'(m_busy[0]));
        chk("a.err",        32'(err_a),            32'(m_err[0]));
        chk("a.cnt",        32'(cnt_a),            exp_cnt(0));
        chk("b.dout",       32'(ifb.dout_o),       exp_dout(1));
        chk("b.steer_o",    32'(ifb.steer_o),      exp_steer(1));
        chk("b.a_comp",     32'(ifb.a_comp_o),     32'(m_busy[1]));
        chk("b.steer_comp", 32'(ifb.steer_comp_o), 32'(m_busy[1]));
        chk("b.err",        32'(err_b),            32'(m_err[1]));
        chk("b.cnt",        32'(cnt_b),            exp_cnt(1));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outs();
    endtask

    task automatic do_reset();
        init_n = 1'b0;
        #1;
        model_reset();
        check_outs();
        init_n = 1'b1;
    endtask

    task automatic drive(input logic [7:0] aa, input logic [2:0] ss, input logic [2:0] dd, input logic cc);
        a = aa; s = ss; dc = dd; sc = cc;
    endtask

    function automatic logic [7:0] rand_word();
        logic [7:0] w;
        w = 8'h00;
        for (int b = 0; b < W; b++) w[2*b +: 2] = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01;
        return w;
    endfunction

    initial begin
        logic [7:0] w;
        logic [2:0] onehot;
        drive(8'h00, 3'b000, 3'b000, 1'b0);
        clr = 1'b0;
        init_n = 1'b0;
        #1;
        model_reset();
        check_outs();
        init_n = 1'b1;
        @(negedge clk);

        // Basic token to channel 1 and its return to NULL.
        drive(8'b01_10_01_10, 3'b010, 3'b000, 1'b0);
        cycle();
        chk("tp.ch1",     32'(ifa.dout_o[15:8]), 32'h66);
        chk("tp.ch0ch2",  32'({ifa.dout_o[23:16], ifa.dout_o[7:0]}), 32'h0);
        chk("tp.steer_o", 32'(ifa.steer_o), 32'b010);
        chk("tp.a_comp",  32'(ifa.a_comp_o), 32'd1);
        chk("tp.cnt1",    32'(cnt_a[15:8]), 32'd1);
        drive(8'h00, 3'b000, 3'b010, 1'b1);
        cycle();
        chk("tp.null",    32'(ifa.dout_o), 32'd0);
        chk("tp.a_comp0", 32'(ifa.a_comp_o), 32'd0);

        // Target channel still holding DATA blocks the token.
        w = rand_word();
        drive(w, 3'b100, 3'b100, 1'b0);
        cycle();
        cycle();
        chk("blk.dout", 32'(ifa.dout_o), 32'd0);
        drive(w, 3'b100, 3'b000, 1'b0);
        cycle();
        chk("blk.ch2", 32'(ifa.dout_o[23:16]), 32'(w));
        drive(8'h00, 3'b000, 3'b100, 1'b1);
        cycle();

        // Busy steer consumer stalls only the forwarding instance.
        drive(rand_word(), 3'b001, 3'b000, 1'b1);
        cycle();
        chk("nofwd.b_comp",  32'(ifb.a_comp_o), 32'd1);
        chk("nofwd.a_comp",  32'(ifa.a_comp_o), 32'd0);
        chk("nofwd.b_steer", 32'(ifb.steer_o), 32'd0);
        drive(8'h00, 3'b000, 3'b001, 1'b0);
        cycle();
        chk("nofwd.b_rel", 32'(ifb.a_comp_o), 32'd0);

        // Randomised well-behaved upstream with glitches, clears and resets.
        for (int n = 0; n < 600; n++) begin
            int busy;
            if ($urandom_range(0, 199) == 0) do_reset();
            busy = ($urandom_range(0, 1) != 0) ? m_busy[0] : m_busy[1];
            onehot = 3'b001 << $urandom_range(0, 2);
            if (busy != 0) begin
                if ($urandom_range(0, 9) == 0) drive(rand_word(), onehot, 3'($urandom), 1'($urandom));
                else                           drive(8'h00, 3'b000, 3'($urandom), 1'($urandom));
            end else begin
                w = rand_word();
                if ($urandom_range(0, 9) == 0) w[1:0] = 2'b00;
                drive(w, onehot, 3'($urandom), 1'($urandom));
            end
            clr = ($urandom_range(0, 15) == 0);
            cycle();
        end
        clr = 1'b0;

        // Counter wrap and clear priority.
        do_reset();
        for (int t = 0; t < 5; t++) begin
            drive(rand_word(), 3'b001, 3'b000, 1'b0);
            cycle();
            drive(8'h00, 3'b000, 3'b001, 1'b1);
            cycle();
        end
        chk("cnt.wrap_b", 32'(cnt_b[1:0]), 32'd1);
        chk("cnt.five_a", 32'(cnt_a[7:0]), 32'd5);
        drive(rand_word(), 3'b001, 3'b000, 1'b0);
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        chk("cnt.clr_b",  32'(cnt_b[1:0]), 32'd0);
        chk("cnt.clr_tk", 32'(ifb.a_comp_o), 32'd1);
        drive(8'h00, 3'b000, 3'b001, 1'b1);
        cycle();

        // Both rails high is sticky until reset.
        w = rand_word() | 8'h03;
        drive(w, 3'b010, 3'b000, 1'b0);
        cycle();
        chk("ill.err_a", 32'(err_a), 32'd1);
        chk("ill.err_b", 32'(err_b), 32'd1);
        chk("ill.dout",  32'(ifa.dout_o), 32'd0);
        for (int t = 0; t < 3; t++) begin
            drive(rand_word(), 3'b001, 3'b000, 1'b0);
            cycle();
            drive(8'h00, 3'b000, 3'b001, 1'b1);
            cycle();
        end
        chk("ill.sticky", 32'(err_a), 32'd1);
        do_reset();
        chk("ill.rst_err",  32'(err_a), 32'd0);
        chk("ill.rst_comp", 32'(ifa.a_comp_o), 32'd0);

        // Multi-hot steer with valid data.
        drive(rand_word(), 3'b011, 3'b000, 1'b0);
        cycle();
        chk("mh.err_a", 32'(err_a), 32'd1);
        chk("mh.err_b", 32'(err_b), 32'd1);
        do_reset();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
